// File: rtl/mem_pkg.sv
// Shared constants for the data-RAM port arbiter and the LSU legality logic.
package mem_pkg;

  localparam logic [2:0] ACC_LB  = 3'b000;
  localparam logic [2:0] ACC_LH  = 3'b001;
  localparam logic [2:0] ACC_LW  = 3'b010;
  localparam logic [2:0] ACC_LBU = 3'b100;
  localparam logic [2:0] ACC_LHU = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check for a RAM access: bad codes, misalignment and
// stores using the unsigned-load codes.
module mem_access_check
  import mem_pkg::*;
(
  input  logic [2:0] access,
  input  logic [1:0] addr_lo,
  input  logic       we,
  output logic       err
);

  always_comb begin
    err = 1'b0;
    case (access)
      ACC_LB:  err = 1'b0;
      ACC_LH:  err = addr_lo[0];
      ACC_LW:  err = (addr_lo != 2'b00);
      ACC_LBU: err = we;
      ACC_LHU: err = we | addr_lo[0];
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port data RAM: fetch (port 0) and
// LSU (port 1), each access sequenced as latch, issue and response cycles.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  output logic                  p0_done,
  output logic [31:0]           p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [2:0]            p1_access,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  output logic                  p1_done,
  output logic [31:0]           p1_rdata,
  output logic                  p1_err,
  output logic                  ram_load,
  output logic                  ram_store,
  output logic [2:0]            ram_access,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out
);

  logic [1:0]            state_q;
  logic                  port_q;
  logic                  we_q;
  logic [2:0]            access_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic                  last_grant_q;

  logic                  grant;
  logic                  sel_we;
  logic [2:0]            sel_access;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_err;

  // Round-robin: on a tie the port that did not go last wins.
  always_comb begin
    grant = p1_req ? PORT_LSU : PORT_FETCH;
    if (p0_req && p1_req) begin
      grant = (FIXED_PRIO != 0) ? PORT_FETCH : ~last_grant_q;
    end
  end

  // Fetches are always word loads.
  assign sel_we     = (grant == PORT_LSU) ? p1_we : 1'b0;
  assign sel_access = (grant == PORT_LSU) ? p1_access : ACC_LW;
  assign sel_addr   = (grant == PORT_LSU) ? p1_addr : p0_addr;

  mem_access_check u_check (
    .access  (sel_access),
    .addr_lo (sel_addr[1:0]),
    .we      (sel_we),
    .err     (sel_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      access_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      err_q        <= 1'b0;
      last_grant_q <= PORT_LSU;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (p0_req || p1_req) begin
            port_q   <= grant;
            we_q     <= sel_we;
            access_q <= sel_access;
            addr_q   <= sel_addr;
            wdata_q  <= p1_wdata;
            err_q    <= sel_err;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_RESP;
        ST_RESP: begin
          last_grant_q <= port_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic        in_issue;
  logic        in_resp;
  logic [31:0] resp_rdata;

  assign in_issue   = (state_q == ST_ISSUE);
  assign in_resp    = (state_q == ST_RESP);
  assign resp_rdata = (!we_q && !err_q) ? ram_data_out : 32'h0;

  assign ram_load    = in_issue & ~err_q & ~we_q;
  assign ram_store   = in_issue & ~err_q & we_q;
  assign ram_access  = in_issue ? access_q : 3'b000;
  assign ram_addr    = in_issue ? addr_q : '0;
  assign ram_data_in = in_issue ? wdata_q : 32'h0;

  assign p0_done  = in_resp & (port_q == PORT_FETCH);
  assign p0_rdata = p0_done ? resp_rdata : 32'h0;
  assign p0_err   = p0_done & err_q;
  assign p1_done  = in_resp & (port_q == PORT_LSU);
  assign p1_rdata = p1_done ? resp_rdata : 32'h0;
  assign p1_err   = p1_done & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter with a byte-array RAM
// and a transaction-level reference model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        p0_req, p0_done, p0_err, p1_req, p1_we, p1_done, p1_err;
  logic [31:0] p0_addr, p0_rdata, p1_addr, p1_wdata, p1_rdata;
  logic [2:0]  p1_access, ram_access;
  logic        ram_load, ram_store;
  logic [31:0] ram_addr, ram_data_in;
  logic [31:0] ram_data_out = 32'h0;

  logic        b_p0_req, b_p0_done, b_p0_err, b_p1_req, b_p1_we, b_p1_done, b_p1_err;
  logic [31:0] b_p0_addr, b_p0_rdata, b_p1_addr, b_p1_wdata, b_p1_rdata;
  logic [2:0]  b_p1_access, b_ram_access;
  logic        b_ram_load, b_ram_store;
  logic [31:0] b_ram_addr, b_ram_data_in;
  logic [31:0] b_ram_data_out = 32'hCAFE_0001;

  mem_port_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_access(p1_access), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .ram_load(ram_load), .ram_store(ram_store), .ram_access(ram_access),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .FIXED_PRIO(1)) dut_fixed (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_addr(b_p0_addr), .p0_done(b_p0_done), .p0_rdata(b_p0_rdata),
    .p0_err(b_p0_err),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_access(b_p1_access), .p1_addr(b_p1_addr),
    .p1_wdata(b_p1_wdata), .p1_done(b_p1_done), .p1_rdata(b_p1_rdata), .p1_err(b_p1_err),
    .ram_load(b_ram_load), .ram_store(b_ram_store), .ram_access(b_ram_access),
    .ram_addr(b_ram_addr), .ram_data_in(b_ram_data_in), .ram_data_out(b_ram_data_out)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem  [0:255];  // RAM contents seen by the DUT
  logic [7:0] gold [0:255];  // reference model's view of memory

  // RAM environment: extension by access code, data registered on the load edge.
  function automatic logic [31:0] env_read(input logic [2:0] acc, input logic [7:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[a]; b1 = mem[a + 8'd1]; b2 = mem[a + 8'd2]; b3 = mem[a + 8'd3];
    case (acc)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_store) begin
      mem[ram_addr[7:0]] <= ram_data_in[7:0];
      if (ram_access[1:0] != 2'b00) mem[ram_addr[7:0] + 8'd1] <= ram_data_in[15:8];
      if (ram_access[1:0] == 2'b10) begin
        mem[ram_addr[7:0] + 8'd2] <= ram_data_in[23:16];
        mem[ram_addr[7:0] + 8'd3] <= ram_data_in[31:24];
      end
    end
    if (ram_load) ram_data_out <= env_read(ram_access, ram_addr[7:0]);
  end

  function automatic bit model_err(input logic [2:0] acc, input int unsigned a, input bit we);
    int unsigned size;
    if (acc == 3'd3 || acc >= 3'd6) return 1'b1;
    if (we && acc >= 3'd4) return 1'b1;
    size = 1 << acc[1:0];
    return (a % size) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] acc, input logic [7:0] a);
    int size;
    logic [31:0] v;
    size = 1 << acc[1:0];
    v = 32'h0;
    for (int i = 0; i < size && i < 4; i++) v = v | (32'(gold[a + 8'(i)]) << (8 * i));
    if (!acc[2] && size < 4 && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input logic [2:0] acc, input logic [7:0] a, input logic [31:0] wd);
    int size;
    size = 1 << acc[1:0];
    for (int i = 0; i < size && i < 4; i++) gold[a + 8'(i)] = wd[8 * i +: 8];
  endtask

  // Drives one transaction from an IDLE cycle and records what the DUT did.
  task automatic run_txn(input bit port, input bit we, input logic [2:0] acc,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output bit o_load, output bit o_store, output int o_lat,
                         output logic [31:0] o_rdata, output bit o_err, output bit o_other,
                         output logic [2:0] o_acc, output logic [31:0] o_addr,
                         output logic [31:0] o_wd);
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_access = acc; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_addr = addr;
    end
    @(negedge clk);
    o_load = ram_load; o_store = ram_store; o_acc = ram_access; o_addr = ram_addr;
    o_wd = ram_data_in;
    o_other = p0_done | p1_done;
    p0_req = 1'b0; p1_req = 1'b0;
    p0_addr = $urandom; p1_addr = $urandom; p1_access = 3'($urandom);
    p1_we = 1'($urandom); p1_wdata = $urandom;
    o_lat = -1; o_rdata = 32'hx; o_err = 1'bx;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      if (port ? p1_done : p0_done) begin
        o_lat = i;
        o_rdata = port ? p1_rdata : p0_rdata;
        o_err = port ? p1_err : p0_err;
        o_other = o_other | (port ? p0_done : p1_done);
        break;
      end
    end
    @(negedge clk);
  endtask

  bit lo, st, er, ot;
  int lat;
  logic [31:0] rd, ad, wd;
  logic [2:0] ac;

  task automatic test_reset();
    rst = 1'b1;
    p0_req = 0; p0_addr = 0; p1_req = 0; p1_we = 0; p1_access = 0; p1_addr = 0; p1_wdata = 0;
    b_p0_req = 0; b_p0_addr = 32'h100; b_p1_req = 0; b_p1_we = 0; b_p1_access = 3'b010;
    b_p1_addr = 32'h104; b_p1_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom); gold[i] = mem[i];
    end
    mem[8'h10] = 8'h78; mem[8'h11] = 8'h56; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;
    for (int i = 16; i < 20; i++) gold[i] = mem[i];
    repeat (2) @(negedge clk);
    vectors++;
    if ({p0_done, p0_rdata, p0_err, p1_done, p1_rdata, p1_err, ram_load, ram_store,
         ram_access, ram_addr, ram_data_in} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: outputs not all zero (p0_done=%b p1_done=%b load=%b store=%b)",
               p0_done, p1_done, ram_load, ram_store);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int cyc [8];
    bit prt [8];
    logic [31:0] dat [8];
    int n = 0;
    p0_req = 1; p0_addr = 32'h10;
    p1_req = 1; p1_we = 0; p1_access = 3'b010; p1_addr = 32'h10;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if ((p0_done || p1_done) && n < 8) begin
        cyc[n] = c; prt[n] = p1_done; dat[n] = p1_done ? p1_rdata : p0_rdata; n++;
      end
    end
    p0_req = 0; p1_req = 0;
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL contention_count: got %0d completions, want 4", n);
    end
    for (int k = 0; k < 4 && k < n; k++) begin
      vectors++;
      if (cyc[k] != 2 + 3 * k || prt[k] !== 1'(k % 2) || dat[k] !== 32'h12345678) begin
        miscompares++;
        $display("FAIL contention_%0d: cycle=%0d port=%0d data=%h, want cycle=%0d port=%0d data=12345678",
                 k, cyc[k], prt[k], dat[k], 2 + 3 * k, k % 2);
      end
    end
  endtask

  task automatic test_single_load();
    run_txn(1, 0, 3'b010, 32'h10, 32'h0, lo, st, lat, rd, er, ot, ac, ad, wd);
    vectors++;
    if (lo !== 1'b1 || st !== 1'b0 || ad !== 32'h10 || ac !== 3'b010) begin
      miscompares++;
      $display("FAIL single_load_issue: load=%b store=%b addr=%h acc=%b, want 1 0 10 010",
               lo, st, ad, ac);
    end
    vectors++;
    if (lat != 2 || rd !== 32'h12345678 || er !== 1'b0 || ot) begin
      miscompares++;
      $display("FAIL single_load_resp: lat=%0d rdata=%h err=%b other=%b, want 2 12345678 0 0",
               lat, rd, er, ot);
    end
  endtask

  task automatic test_store_load();
    run_txn(1, 1, 3'b000, 32'h21, 32'h000000F0, lo, st, lat, rd, er, ot, ac, ad, wd);
    model_store(3'b000, 8'h21, 32'h000000F0);
    vectors++;
    if (st !== 1'b1 || lo !== 1'b0 || wd !== 32'hF0 || lat != 2 || rd !== 32'h0 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL store_byte: store=%b load=%b wdata=%h lat=%0d rdata=%h err=%b",
               st, lo, wd, lat, rd, er);
    end
    run_txn(1, 0, 3'b000, 32'h21, 32'h0, lo, st, lat, rd, er, ot, ac, ad, wd);
    vectors++;
    if (rd !== 32'hFFFFFFF0 || er !== 1'b0 || lat != 2) begin
      miscompares++;
      $display("FAIL load_lb: rdata=%h err=%b lat=%0d, want FFFFFFF0 0 2", rd, er, lat);
    end
    run_txn(1, 0, 3'b100, 32'h21, 32'h0, lo, st, lat, rd, er, ot, ac, ad, wd);
    vectors++;
    if (rd !== 32'h000000F0 || er !== 1'b0 || lat != 2) begin
      miscompares++;
      $display("FAIL load_lbu: rdata=%h err=%b lat=%0d, want 000000F0 0 2", rd, er, lat);
    end
  endtask

  task automatic test_illegal();
    run_txn(1, 1, 3'b010, 32'h22, 32'hA5A5A5A5, lo, st, lat, rd, er, ot, ac, ad, wd);
    vectors++;
    if (st !== 1'b0 || lo !== 1'b0 || lat != 2 || er !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL misaligned_sw: store=%b load=%b lat=%0d err=%b rdata=%h, want 0 0 2 1 0",
               st, lo, lat, er, rd);
    end
    run_txn(1, 0, 3'b010, 32'h20, 32'h0, lo, st, lat, rd, er, ot, ac, ad, wd);
    vectors++;
    if (rd !== model_load(3'b010, 8'h20) || er !== 1'b0) begin
      miscompares++;
      $display("FAIL ram_untouched: word at 20 = %h, want %h", rd, model_load(3'b010, 8'h20));
    end
    run_txn(0, 0, 3'b010, 32'h6, 32'h0, lo, st, lat, rd, er, ot, ac, ad, wd);
    vectors++;
    if (lo !== 1'b0 || lat != 2 || er !== 1'b1 || rd !== 32'h0 || ot) begin
      miscompares++;
      $display("FAIL misaligned_fetch: load=%b lat=%0d err=%b rdata=%h other=%b, want 0 2 1 0 0",
               lo, lat, er, rd, ot);
    end
  endtask

  task automatic test_fixed_prio();
    int n0 = 0, n1 = 0, bad_cyc = 0;
    b_p0_req = 1; b_p1_req = 1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (b_p0_done) begin
        if (c != 2 + 3 * n0 || b_p0_rdata !== 32'hCAFE0001) bad_cyc++;
        n0++;
      end
      if (b_p1_done) n1++;
    end
    b_p0_req = 0; b_p1_req = 0;
    vectors++;
    if (n0 != 4 || n1 != 0 || bad_cyc != 0) begin
      miscompares++;
      $display("FAIL fixed_prio: p0 grants=%0d p1 grants=%0d bad=%0d, want 4 0 0", n0, n1, bad_cyc);
    end
  endtask

  task automatic test_reset_in_issue();
    int first_lat = -1;
    bit first_port = 1'b0;
    run_txn(0, 0, 3'b010, 32'h10, 32'h0, lo, st, lat, rd, er, ot, ac, ad, wd);
    p1_req = 1; p1_we = 1; p1_access = 3'b010; p1_addr = 32'h30; p1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    p1_req = 0;
    vectors++;
    if (ram_store !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_issue_pre: ram_store=%b, want 1", ram_store);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({ram_load, ram_store, ram_access, ram_addr, ram_data_in, p0_done, p1_done} !== '0) begin
      miscompares++;
      $display("FAIL rst_issue_zero: store=%b addr=%h data=%h, want all 0",
               ram_store, ram_addr, ram_data_in);
    end
    @(negedge clk);
    vectors++;
    if (p1_done !== 1'b0 || p0_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_issue_done: p0_done=%b p1_done=%b, want 0 0", p0_done, p1_done);
    end
    rst = 1'b0;
    @(negedge clk);
    p0_req = 1; p0_addr = 32'h10;
    p1_req = 1; p1_we = 0; p1_access = 3'b010; p1_addr = 32'h30;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        p0_req = 0; p1_req = 0;
      end
      if ((p0_done || p1_done) && first_lat < 0) begin
        first_lat = c; first_port = p1_done;
      end
    end
    vectors++;
    if (first_lat != 2 || first_port !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_tie_winner: lat=%0d port=%0d, want 2 0", first_lat, first_port);
    end
    run_txn(1, 0, 3'b010, 32'h30, 32'h0, lo, st, lat, rd, er, ot, ac, ad, wd);
    vectors++;
    if (rd !== model_load(3'b010, 8'h30) || lat != 2) begin
      miscompares++;
      $display("FAIL rst_store_dropped: word at 30 = %h, want %h", rd, model_load(3'b010, 8'h30));
    end
  endtask

  task automatic test_random();
    bit port, we, e_err;
    logic [2:0] acc;
    logic [31:0] addr, wdata, e_rd;
    for (int n = 0; n < 60; n++) begin
      port = ($urandom_range(0, 3) != 0);
      acc = port ? 3'($urandom) : 3'b010;
      we = port ? 1'($urandom) : 1'b0;
      addr = 32'($urandom_range(64, 255));
      if ($urandom_range(0, 2) != 0) addr = addr & ~((32'd1 << acc[1:0]) - 32'd1);
      wdata = $urandom;
      e_err = model_err(acc, addr, we);
      e_rd = (!e_err && !we) ? model_load(acc, addr[7:0]) : 32'h0;
      run_txn(port, we, acc, addr, wdata, lo, st, lat, rd, er, ot, ac, ad, wd);
      vectors++;
      if (lo !== (!e_err && !we) || st !== (!e_err && we) || ac !== acc || ad !== addr) begin
        miscompares++;
        $display("FAIL rand_issue_%0d: port=%0d acc=%b addr=%h we=%b -> load=%b store=%b ac=%b ad=%h",
                 n, port, acc, addr, we, lo, st, ac, ad);
      end
      vectors++;
      if (lat != 2 || er !== e_err || rd !== e_rd || ot) begin
        miscompares++;
        $display("FAIL rand_resp_%0d: port=%0d acc=%b addr=%h lat=%0d err=%b rdata=%h other=%b, want 2 %b %h 0",
                 n, port, acc, addr, lat, er, rd, ot, e_err, e_rd);
      end
      if (!e_err && we) model_store(acc, addr[7:0], wdata);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_load();
    test_store_load();
    test_illegal();
    test_fixed_prio();
    test_reset_in_issue();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
